// File: rtl/rock_spawner.sv
// rock_spawner: spawn scheduler and retirement logic for the pool of rock slots.
//
// Each frame tick a spawn timer counts down. When it expires, the FSM picks the
// lowest-numbered idle slot and latches a pseudo-random edge position and an
// inward direction from a free-running LFSR. It then pulses that slot's start
// line for one cycle. Independently of the FSM, every active slot has a
// lifetime counter. A slot is killed when the counter expires or on a
// collision request.
//
// Ports
//   clk60hz     in   frame-rate clock shared with the rock slots
//   reset       in   asynchronous active-high reset
//   enable      in   spawning allowed; low returns the FSM to IDLE
//   inUse       in   [NUM_ROCKS] per-slot active flags
//   destroy     in   [NUM_ROCKS] per-slot collision kill request (level)
//   start       out  [NUM_ROCKS] one-hot one-cycle spawn pulse
//   kill        out  [NUM_ROCKS] one-cycle reset pulse per slot
//   initialX    out  [10] spawn X, held between spawns
//   initialY    out  [10] spawn Y, held between spawns
//   dirX        out  [3] sign-magnitude X velocity (bit2 = negative)
//   dirY        out  [3] sign-magnitude Y velocity (bit2 = negative)
//   rock_count  out  [4] popcount of inUse (combinational)
//   dbg_state   out  [3] current FSM state
//
// Handshake: start is a single-cycle strobe with no back-pressure. The
// position and direction outputs are stable for the whole start cycle. The
// slot acknowledges by raising inUse, which SETTLE waits for (bounded).
module rock_spawner #(
  parameter int          NUM_ROCKS    = 4,
  parameter int          SPAWN_PERIOD = 120,
  parameter int          LIFETIME     = 600,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk60hz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_ROCKS-1:0] inUse,
  input  logic [NUM_ROCKS-1:0] destroy,
  output logic [NUM_ROCKS-1:0] start,
  output logic [NUM_ROCKS-1:0] kill,
  output logic [9:0]           initialX,
  output logic [9:0]           initialY,
  output logic [2:0]           dirX,
  output logic [2:0]           dirY,
  output logic [3:0]           rock_count,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_PICK   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  localparam int          TW         = $clog2(SPAWN_PERIOD);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SPAWN_PERIOD - 1);
  localparam logic [9:0]  LIFE_LAST  = 10'(LIFETIME - 1);

  logic [2:0]           r_state;
  logic [TW-1:0]        r_timer;
  logic                 r_settle;
  logic [NUM_ROCKS-1:0] r_slot_oh;
  logic [15:0]          r_lfsr;
  logic [9:0]           r_init_x;
  logic [9:0]           r_init_y;
  logic [2:0]           r_dir_x;
  logic [2:0]           r_dir_y;
  logic [NUM_ROCKS-1:0] r_kill;
  logic [9:0]           r_life [NUM_ROCKS];

  // ---------------- LFSR: taps 16,14,13,11, right-shifting ----------------
  logic w_fb;
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk60hz or posedge reset) begin
    if (reset)              r_lfsr <= LFSR_SEED;
    else if (r_lfsr == '0)  r_lfsr <= LFSR_SEED;
    else                    r_lfsr <= {w_fb, r_lfsr[15:1]};
  end

  // ---------------- Spawn decode from the current LFSR value ----------------
  logic [9:0] w_r;
  logic [9:0] w_ry;
  logic [1:0] w_mx;
  logic [1:0] w_my;
  logic [9:0] w_x;
  logic [9:0] w_y;
  logic [2:0] w_dx;
  logic [2:0] w_dy;

  assign w_r  = {1'b0, r_lfsr[14:6]};
  // Fold the 480..511 band back into range so Y always lands on screen.
  assign w_ry = (w_r >= 10'd480) ? (w_r - 10'd256) : w_r;
  assign w_mx = (r_lfsr[3:2] == 2'd0) ? 2'd1 : r_lfsr[3:2];
  assign w_my = (r_lfsr[5:4] == 2'd0) ? 2'd1 : r_lfsr[5:4];

  always_comb begin
    w_x  = '0;
    w_y  = '0;
    w_dx = '0;
    w_dy = '0;
    case (r_lfsr[1:0])
      2'd0: begin w_x = 10'd0;   w_y = w_ry;    w_dx = {1'b0, w_mx};      w_dy = {r_lfsr[15], w_my}; end
      2'd1: begin w_x = 10'd639; w_y = w_ry;    w_dx = {1'b1, w_mx};      w_dy = {r_lfsr[15], w_my}; end
      2'd2: begin w_x = w_r;     w_y = 10'd0;   w_dx = {r_lfsr[15], w_mx}; w_dy = {1'b0, w_my};     end
      default: begin w_x = w_r;  w_y = 10'd479; w_dx = {r_lfsr[15], w_mx}; w_dy = {1'b1, w_my};     end
    endcase
  end

  // ---------------- Lowest free slot (idle and not being killed) -----------
  logic [NUM_ROCKS-1:0] w_free;
  logic [NUM_ROCKS-1:0] w_pick_oh;
  logic                 w_found;

  assign w_free  = ~inUse & ~r_kill;
  assign w_found = |w_free;

  always_comb begin
    w_pick_oh = '0;
    for (int i = NUM_ROCKS - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_pick_oh    = '0;
        w_pick_oh[i] = 1'b1;
      end
    end
  end

  // ---------------- Spawn FSM ----------------
  always_ff @(posedge clk60hz or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_settle  <= 1'b0;
      r_slot_oh <= '0;
      r_init_x  <= '0;
      r_init_y  <= '0;
      r_dir_x   <= '0;
      r_dir_y   <= '0;
    end else if (!enable) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= TIMER_LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_timer == '0) r_state <= S_PICK;
          else               r_timer <= r_timer - 1'b1;
        end
        S_PICK: begin
          // No free slot: stay here and retry; the timer is not reloaded.
          if (w_found) begin
            r_slot_oh <= w_pick_oh;
            r_init_x  <= w_x;
            r_init_y  <= w_y;
            r_dir_x   <= w_dx;
            r_dir_y   <= w_dy;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_settle <= 1'b0;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          // Leave once the slot reports active, or after two cycles anyway.
          if ((|(inUse & r_slot_oh)) || r_settle) begin
            r_timer <= TIMER_LOAD;
            r_state <= S_WAIT;
          end else begin
            r_settle <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // start is gated by enable so dropping enable suppresses the pulse at once.
  assign start = ((r_state == S_ISSUE) && enable) ? r_slot_oh : '0;

  // ---------------- Lifetime counters and kill pulses ----------------
  always_ff @(posedge clk60hz or posedge reset) begin
    if (reset) begin
      r_kill <= '0;
      for (int i = 0; i < NUM_ROCKS; i++) r_life[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ROCKS; i++) begin
        if (!inUse[i]) begin
          r_life[i] <= '0;
          r_kill[i] <= 1'b0;
        end else if (destroy[i] || (r_life[i] == LIFE_LAST)) begin
          // Collision and expiry in the same cycle collapse to one pulse.
          r_life[i] <= '0;
          r_kill[i] <= 1'b1;
        end else begin
          r_life[i] <= r_life[i] + 10'd1;
          r_kill[i] <= 1'b0;
        end
      end
    end
  end

  assign kill = r_kill;

  // ---------------- Active rock count ----------------
  always_comb begin
    rock_count = '0;
    for (int i = 0; i < NUM_ROCKS; i++) rock_count = rock_count + 4'(inUse[i]);
  end

  assign initialX  = r_init_x;
  assign initialY  = r_init_y;
  assign dirX      = r_dir_x;
  assign dirY      = r_dir_y;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rock_spawner.sv
// Directed bench for rock_spawner with a small LFSR/decode reference model and
// an expected-slot queue for spawn pulses.
module tb_rock_spawner;

  localparam int          NR   = 4;
  localparam int          P    = 4;
  localparam int          LT   = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk60hz = 1'b0;
  logic          reset;
  logic          enable;
  logic [NR-1:0] inUse;
  logic [NR-1:0] destroy;
  logic [NR-1:0] start;
  logic [NR-1:0] kill;
  logic [9:0]    initialX;
  logic [9:0]    initialY;
  logic [2:0]    dirX;
  logic [2:0]    dirY;
  logic [3:0]    rock_count;
  logic [2:0]    dbg_state;

  rock_spawner #(
    .NUM_ROCKS(NR), .SPAWN_PERIOD(P), .LIFETIME(LT), .LFSR_SEED(SEED)
  ) dut (
    .clk60hz(clk60hz), .reset(reset), .enable(enable), .inUse(inUse),
    .destroy(destroy), .start(start), .kill(kill), .initialX(initialX),
    .initialY(initialY), .dirX(dirX), .dirY(dirY), .rock_count(rock_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk60hz = ~clk60hz;

  // ---------------- counters and scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [NR-1:0] exp_q[$];
  logic [3:0]    edge_mask = '0;

  // ---------------- reference LFSR ----------------
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;   // value during the previous cycle (what PICK saw)

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic b;
    if (l == 16'h0) return SEED;
    b = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {b, l[15:1]};
  endfunction

  always @(posedge clk60hz or posedge reset) begin
    if (reset) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  task automatic exp_decode(input logic [15:0] l, output logic [9:0] x,
                            output logic [9:0] y, output logic [2:0] dx,
                            output logic [2:0] dy);
    logic [9:0] r;
    logic [9:0] ry;
    logic [1:0] mx;
    logic [1:0] my;
    r  = {1'b0, l[14:6]};
    ry = (r >= 10'd480) ? r - 10'd256 : r;
    mx = (l[3:2] == 2'd0) ? 2'd1 : l[3:2];
    my = (l[5:4] == 2'd0) ? 2'd1 : l[5:4];
    case (l[1:0])
      2'd0:    begin x = 10'd0;   y = ry;      dx = {1'b0, mx};  dy = {l[15], my}; end
      2'd1:    begin x = 10'd639; y = ry;      dx = {1'b1, mx};  dy = {l[15], my}; end
      2'd2:    begin x = r;       y = 10'd0;   dx = {l[15], mx}; dy = {1'b0, my};  end
      default: begin x = r;       y = 10'd479; dx = {l[15], mx}; dy = {1'b1, my};  end
    endcase
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk60hz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] lowest_free(input logic [NR-1:0] u);
    logic [NR-1:0] oh;
    oh = '0;
    for (int i = NR - 1; i >= 0; i--) if (!u[i]) begin oh = '0; oh[i] = 1'b1; end
    return oh;
  endfunction

  // Compare a start pulse observed now against the queue head and the model.
  task automatic check_spawn();
    logic [NR-1:0] e;
    logic [9:0] ex, ey;
    logic [2:0] edx, edy;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("start_slot", 32'(start), 32'(e));
    exp_decode(m_prev, ex, ey, edx, edy);
    chk("initialX", 32'(initialX), 32'(ex));
    chk("initialY", 32'(initialY), 32'(ey));
    chk("dirX", 32'(dirX), 32'(edx));
    chk("dirY", 32'(dirY), 32'(edy));
    chk("y_on_screen", 32'(initialY < 10'd480), 32'd1);
    chk("mag_nonzero", 32'((dirX[1:0] != 2'd0) && (dirY[1:0] != 2'd0)), 32'd1);
    edge_mask[m_prev[1:0]] = 1'b1;
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end while (start == '0 && n < budget);
    if (start == '0) begin
      vectors++;
      miscompares++;
      $error("FAIL start_timeout: observed no start within %0d cycles, expected 0x%0h",
             budget, (exp_q.size() > 0) ? exp_q[0] : '0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check_spawn();
    end
  endtask

  // start and kill on the same slot must never coincide.
  always @(negedge clk60hz) begin
    if (!reset && start != '0) chk("start_kill_overlap", 32'(start & kill), 32'd0);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [NR-1:0] u;
    logic [NR-1:0] any_start;
    reset   = 1'b1;
    enable  = 1'b0;
    inUse   = '0;
    destroy = '0;
    tick();
    tick();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_kill", 32'(kill), 32'd0);
    chk("rst_xy", 32'({initialX, initialY}), 32'd0);
    chk("rst_dir", 32'({dirX, dirY}), 32'd0);
    reset = 1'b0;
    inUse = 4'b0101;
    #1;
    chk("rock_count_2", 32'(rock_count), 32'd2);
    inUse = 4'b1111;
    #1;
    chk("rock_count_4", 32'(rock_count), 32'd4);
    inUse = '0;
    tick();

    // First spawn lands P+2 edges after enable rises.
    enable = 1'b1;
    exp_q.push_back(4'b0001);
    for (int k = 1; k < P + 2; k++) begin
      tick();
      chk("first_spawn_early", 32'(start), 32'd0);
    end
    tick();
    check_spawn();
    tick();
    chk("start_one_cycle", 32'(start), 32'd0);

    // Lowest free slot with the three low slots busy.
    inUse = 4'b0111;
    exp_q.push_back(4'b1000);
    wait_start(20);

    // All busy: FSM must hold in PICK without issuing.
    inUse = 4'b1111;
    any_start = '0;
    for (int k = 0; k < 15; k++) begin tick(); any_start |= start; end
    chk("full_no_start", 32'(any_start), 32'd0);
    if (kill[2]) tick();
    inUse = 4'b1011;
    exp_q.push_back(4'b0100);
    tick();
    check_spawn();

    // Random occupancy, held across each interval, until all four edges seen.
    for (int s = 0; s < 40 && edge_mask != 4'hF; s++) begin
      u = 4'($urandom_range(0, 14));
      inUse = u;
      exp_q.push_back(lowest_free(u));
      wait_start(20);
    end
    chk("all_edges_seen", 32'(edge_mask), 32'hF);

    // Lifetime expiry on slot 1.
    enable = 1'b0;
    inUse  = '0;
    tick();
    tick();
    inUse = 4'b0010;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k < LT; k++) begin
        tick();
        chk("life_early", 32'(kill), 32'd0);
      end
      tick();
      chk("life_kill", 32'(kill), 32'b0010);
    end
    tick();
    chk("life_kill_width", 32'(kill), 32'd0);
    inUse = '0;
    tick();

    // Collision kill, then collision coinciding with expiry.
    inUse = 4'b0100;
    tick();
    tick();
    destroy = 4'b0100;
    tick();
    chk("destroy_kill", 32'(kill), 32'b0100);
    destroy = '0;
    tick();
    chk("destroy_width", 32'(kill), 32'd0);
    for (int k = 2; k < LT; k++) tick();
    destroy = 4'b0100;
    tick();
    chk("dual_kill", 32'(kill), 32'b0100);
    destroy = '0;
    tick();
    chk("dual_single_pulse", 32'(kill), 32'd0);
    inUse   = '0;
    destroy = 4'b1000;
    tick();
    chk("destroy_idle_ignored", 32'(kill), 32'd0);
    destroy = '0;
    tick();

    // Enable dropped during WAIT restarts the full interval.
    enable = 1'b1;
    tick();
    tick();
    tick();
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    exp_q.push_back(4'b0001);
    for (int k = 1; k < P + 2; k++) begin
      tick();
      chk("reenable_early", 32'(start), 32'd0);
    end
    tick();
    check_spawn();

    // Reset in the middle of ISSUE drops start immediately.
    reset = 1'b1;
    #1;
    chk("mid_rst_start", 32'(start), 32'd0);
    chk("mid_rst_xy", 32'({initialX, initialY}), 32'd0);
    chk("mid_rst_dir", 32'({dirX, dirY}), 32'd0);
    tick();
    reset = 1'b0;
    exp_q.push_back(4'b0001);
    for (int k = 1; k < P + 2; k++) begin
      tick();
      chk("post_rst_early", 32'(start), 32'd0);
    end
    tick();
    check_spawn();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rock_spawner.md
# rock_spawner

Scheduler for the pool of asteroid (rock) slots. Each frame tick it counts down a spawn interval, finds the lowest-numbered idle slot, and generates a pseudo-random edge position and inward direction. It then pulses that slot's start line. It also retires rocks: a slot is killed on a collision request or when its lifetime expires. It sits between game control/collision logic and the array of rock instances, driving their shared initialX/initialY/dirX/dirY buses and per-slot start/reset lines.

## Interface
- NUM_ROCKS, 4, number of rock slots (1–8)
- SPAWN_PERIOD, 120, ticks between spawn attempts (≥2)
- LIFETIME, 600, ticks a rock lives before forced kill (≤1023)
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)
- clk60hz  in  1  frame-rate clock, shared with rock slots
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  spawning allowed; low returns FSM to IDLE
- inUse  in  NUM_ROCKS  per-slot active flags from rock slots
- destroy  in  NUM_ROCKS  per-slot kill request (collision), level-sampled
- start  out  NUM_ROCKS  one-hot, one-cycle spawn pulse
- kill  out  NUM_ROCKS  per-slot one-cycle reset pulse to the rock slots
- initialX  out  10  spawn X, valid while start is high
- initialY  out  10  spawn Y, valid while start is high
- dirX  out  3  sign-magnitude X velocity: bit2=1 means negative
- dirY  out  3  sign-magnitude Y velocity: bit2=1 means negative
- rock_count  out  4  popcount of inUse, combinational

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle regardless of enable. If its value reaches 0, it reloads LFSR_SEED.
- FSM states: IDLE, WAIT, PICK, ISSUE, SETTLE.
  - IDLE: when enable=1, load spawn timer with SPAWN_PERIOD-1 and go to WAIT.
  - WAIT: decrement the timer; at 0, go to PICK.
  - PICK: select the lowest index i with inUse[i]=0 and kill[i]=0. Latch slot, position and direction from the current LFSR, then go to ISSUE. With no free slot, stay in PICK and retry every cycle; the timer is not reloaded.
  - ISSUE: start[slot]=1 for exactly one cycle, then go to SETTLE.
  - SETTLE: wait for inUse[slot]=1, or 2 cycles maximum. Then reload the timer and go to WAIT.
  - enable=0 in any state: go to IDLE at the next edge; start is 0 in that cycle.
- Position (screen 640×480). Edge select e = lfsr[1:0]:
  - e=0: left edge, X=0.
  - e=1: right edge, X=639.
  - e=2: top edge, Y=0.
  - e=3: bottom edge, Y=479.
  - Free coordinate r = lfsr[14:6], a 9-bit value, widened to 10 bits. For Y, if r ≥ 480 use r−256. For X, use r directly (0–511).
- Direction:
  - Magnitudes: mX = lfsr[3:2], mY = lfsr[5:4]; any magnitude of 0 is forced to 1.
  - The axis normal to the spawn edge gets the inward sign: left→+X, right→−X, top→+Y, bottom→−Y.
  - The other axis takes its sign from lfsr[15].
- Lifetime: one 10-bit counter per slot.
  - Counter is cleared while inUse[i]=0 and increments while inUse[i]=1.
  - When it reaches LIFETIME−1, kill[i] pulses and the counter clears.
- destroy[i]=1 while inUse[i]=1 pulses kill[i] for one cycle.
  - Any kill[i] pulse, from lifetime or destroy, also clears that slot's lifetime counter.
  - destroy on an idle slot is ignored.
- kill logic is independent of enable and of FSM state.
- Outputs initialX/initialY/dirX/dirY are registered and hold their last latched values between spawns.

## Timing
- Reset values:
  - start, kill: 0.
  - initialX, initialY, dirX, dirY: 0.
  - FSM: IDLE; spawn timer: 0.
  - lifetime counters: 0; LFSR: LFSR_SEED.
  - rock_count follows inUse.
- Spawn interval: from enable rising, the first start pulse occurs SPAWN_PERIOD+2 edges later. Steady-state spawns are SPAWN_PERIOD+3 to +4 cycles apart.
- initialX/initialY/dirX/dirY become valid on the edge entering ISSUE, one cycle before or coincident with start. They are stable for the whole start cycle.
- Simultaneous destroy[i] and lifetime expiry on slot i: a single kill pulse.
- kill[i] and start[i] are never high in the same cycle: PICK excludes slots with kill asserted.
- Reset asserted mid-ISSUE: start drops immediately (asynchronous).

## Test plan
- Reset then enable=1, SPAWN_PERIOD=4, all inUse=0 → start=4'b0001 exactly once, 6 edges after enable. initialX/initialY/dirX/dirY match the reference-model LFSR decode for that cycle.
- inUse=4'b0111 while in WAIT → next start=4'b1000; with inUse=4'b1111 the FSM holds in PICK. Dropping inUse[2] → start=4'b0100 next cycle.
- Slot 1 held inUse=1, LIFETIME=10 → kill=4'b0010 on the 10th edge after inUse rises, one cycle wide, and the counter restarts.
- destroy=4'b0100 with inUse[2]=1 → kill[2] one-cycle pulse; destroy[3] with inUse[3]=0 → no kill.
- Spawn on each edge case: force LFSR states giving e=0..3 → X=0/639 or Y=0/479, inward sign correct, magnitudes never 0, Y never ≥480.
- enable dropped during WAIT and re-raised, plus reset asserted during ISSUE → no start pulse until a full SPAWN_PERIOD elapses; all outputs are 0 right after reset.
